pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives hold and bubble controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves three hazard sources:
  - load-use data hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses, with a timeout watchdog.
- Keeps a saturating stall-cycle counter for trace/performance readout.

---
 rtl/pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It resolves three
// hazard sources and drives hold/bubble controls into the pipeline registers:
//   - load-use data hazards
//   - taken branches/jumps resolved in EX
//   - multi-cycle data-memory accesses, guarded by a timeout watchdog
// A saturating stall-cycle counter is kept for trace/performance readout.
//
// Parameters:
//   MEM_TIMEOUT : maximum MEM_WAIT cycles without mem_ack before abort (>= 2)
//   CNT_W       : width of stall_cnt
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   id_rs1/id_rs2         : source register indices of the ID instruction
//   id_rs1_used/_rs2_used : ID instruction actually reads rs1/rs2
//   ex_wR, ex_rf_we       : EX destination register and its write enable
//   ex_is_load            : EX instruction is a load
//   ex_br_taken           : EX redirects the PC
//   mem_req, mem_ack      : MEM stage access request / data bus completion
//   pc_stall ..
//   mem_wb_bubble         : pipeline register hold/flush/bubble controls
//   mem_err               : sticky memory-timeout flag
//   stall_cnt             : saturating count of cycles with pc_stall=1
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_wR,
    input  logic             ex_rf_we,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_ZERO = WC_W'(0);
    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [WC_W-1:0]   wait_cnt_s;
    logic              mem_err_r;
    logic              mem_err_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic              load_use_s;
    logic              mem_busy_s;

    // Raw controls before reset gating.
    logic              pc_stall_s;
    logic              if_id_stall_s;
    logic              if_id_flush_s;
    logic              id_ex_stall_s;
    logic              id_ex_flush_s;
    logic              ex_mem_stall_s;
    logic              mem_wb_bubble_s;

    // Hazard detection terms; x0 is never a real dependency.
    always_comb begin
        load_use_s = ex_is_load & ex_rf_we & (ex_wR != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_wR)) |
                      (id_rs2_used & (id_rs2 == ex_wR)));
        mem_busy_s = mem_req & ~mem_ack;
    end

    // Next-state, watchdog and control decode. Memory stall outranks the
    // branch flush, which outranks load-use (the ID instruction is squashed).
    always_comb begin
        state_s         = state_r;
        wait_cnt_s      = wait_cnt_r;
        mem_err_s       = mem_err_r;
        pc_stall_s      = 1'b0;
        if_id_stall_s   = 1'b0;
        if_id_flush_s   = 1'b0;
        id_ex_stall_s   = 1'b0;
        id_ex_flush_s   = 1'b0;
        ex_mem_stall_s  = 1'b0;
        mem_wb_bubble_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_busy_s) begin
                    pc_stall_s      = 1'b1;
                    if_id_stall_s   = 1'b1;
                    id_ex_stall_s   = 1'b1;
                    ex_mem_stall_s  = 1'b1;
                    mem_wb_bubble_s = 1'b1;
                    state_s         = ST_MEM_WAIT;
                    wait_cnt_s      = WC_ONE;
                end else if (ex_br_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else if (load_use_s) begin
                    pc_stall_s    = 1'b1;
                    if_id_stall_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                end else begin
                    wait_cnt_s = WC_ZERO;
                end
            end
            ST_MEM_WAIT: begin
                // Whole front of the pipe stays frozen, including a pending
                // branch in EX; it is acted on once back in RUN.
                pc_stall_s      = 1'b1;
                if_id_stall_s   = 1'b1;
                id_ex_stall_s   = 1'b1;
                ex_mem_stall_s  = 1'b1;
                mem_wb_bubble_s = 1'b1;
                if (mem_ack) begin
                    state_s    = ST_RUN;
                    wait_cnt_s = WC_ZERO;
                end else if (wait_cnt_r == WC_LAST) begin
                    // Abort: flag the error and release the pipe as if done.
                    mem_err_s  = 1'b1;
                    state_s    = ST_RUN;
                    wait_cnt_s = WC_ZERO;
                end else begin
                    wait_cnt_s = wait_cnt_r + WC_ONE;
                end
            end
            default: begin
                state_s    = ST_RUN;
                wait_cnt_s = WC_ZERO;
            end
        endcase
    end

    // Controls are forced low whenever reset is held.
    always_comb begin
        if (rst_n) begin
            pc_stall      = pc_stall_s;
            if_id_stall   = if_id_stall_s;
            if_id_flush   = if_id_flush_s;
            id_ex_stall   = id_ex_stall_s;
            id_ex_flush   = id_ex_flush_s;
            ex_mem_stall  = ex_mem_stall_s;
            mem_wb_bubble = mem_wb_bubble_s;
        end else begin
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_stall   = 1'b0;
            id_ex_flush   = 1'b0;
            ex_mem_stall  = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    // FSM state, watchdog counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= WC_ZERO;
            mem_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            mem_err_r  <= mem_err_s;
        end
    end

    // Saturating count of PC-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= '0;
        end else if (pc_stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign mem_err   = mem_err_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = 5'd0;
    logic [4:0]  id_rs2 = 5'd0;
    logic        id_rs1_used = 1'b0;
    logic        id_rs2_used = 1'b0;
    logic [4:0]  ex_wR = 5'd0;
    logic        ex_rf_we = 1'b0;
    logic        ex_is_load = 1'b0;
    logic        ex_br_taken = 1'b0;
    logic        mem_req = 1'b0;
    logic        mem_ack = 1'b0;

    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic        ex_mem_stall, mem_wb_bubble, mem_err;
    logic [31:0] stall_cnt;

    logic        s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_flush;
    logic        s_ex_mem_stall, s_mem_wb_bubble, s_mem_err;
    logic [3:0]  s_stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_bubble}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_MEM    = 7'b1101011;
    localparam logic [6:0] C_LDUSE  = 7'b1100100;
    localparam logic [6:0] C_BRANCH = 7'b0010100;

    logic [6:0] ctrl;
    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, mem_wb_bubble};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_wR(ex_wR), .ex_rf_we(ex_rf_we), .ex_is_load(ex_is_load),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
        .id_ex_stall(s_id_ex_stall), .id_ex_flush(s_id_ex_flush),
        .ex_mem_stall(s_ex_mem_stall), .mem_wb_bubble(s_mem_wb_bubble),
        .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: entered at posedge+2, checks controls mid-cycle, then
    // advances to the next posedge+2 and updates the expected stall count.
    task automatic cyc(input string tag, input logic [6:0] exp_ctrl);
        #3;
        check(tag, {25'd0, ctrl}, {25'd0, exp_ctrl});
        @(posedge clk);
        #2;
        if (exp_ctrl[6]) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic set_load_use(input logic [4:0] wr);
        ex_is_load  = 1'b1;
        ex_rf_we    = 1'b1;
        ex_wR       = wr;
        id_rs1      = 5'd5;
        id_rs1_used = 1'b1;
        id_rs2      = 5'd7;
        id_rs2_used = 1'b0;
    endtask

    task automatic clear_ex;
        ex_is_load  = 1'b0;
        ex_rf_we    = 1'b0;
        ex_wR       = 5'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        ex_br_taken = 1'b0;
        mem_req     = 1'b0;
        mem_ack     = 1'b0;
    endtask

    initial begin
        // Reset: outputs gated low even with a pending memory request.
        mem_req = 1'b1;
        #12;
        check("rst_ctrl", {25'd0, ctrl}, 32'd0);
        check("rst_cnt", stall_cnt, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        mem_req = 1'b0;
        #5 rst_n = 1'b1;                    // t=17, posedge+2

        cyc("idle", C_NONE);

        // Load-use on rs1: single bubble, then load moves on.
        set_load_use(5'd5);
        cyc("lduse_rs1", C_LDUSE);
        check("lduse_cnt", stall_cnt, exp_cnt);
        clear_ex;
        cyc("lduse_after", C_NONE);

        // Destination x0 never hazards.
        set_load_use(5'd0);
        id_rs1 = 5'd0;
        cyc("lduse_x0", C_NONE);

        // rs2 path, and unused rs1 masked.
        set_load_use(5'd7);
        id_rs1 = 5'd7;
        id_rs1_used = 1'b0;
        cyc("lduse_rs1_unused", C_NONE);
        id_rs2_used = 1'b1;
        cyc("lduse_rs2", C_LDUSE);
        // Non-load producer gives no stall.
        ex_is_load = 1'b0;
        cyc("nonload", C_NONE);

        // Branch plus load-use: branch wins, no stall.
        set_load_use(5'd5);
        ex_br_taken = 1'b1;
        cyc("br_lduse", C_BRANCH);
        check("br_lduse_cnt", stall_cnt, exp_cnt);
        clear_ex;

        // Zero-wait memory access.
        mem_req = 1'b1;
        mem_ack = 1'b1;
        cyc("mem_zero_wait", C_NONE);

        // Memory wait: ack low 3 cycles then high -> 4 stall cycles.
        mem_ack = 1'b0;
        cyc("mem_w1", C_MEM);
        cyc("mem_w2", C_MEM);
        cyc("mem_w3", C_MEM);
        mem_ack = 1'b1;
        cyc("mem_w4", C_MEM);
        clear_ex;
        cyc("mem_done", C_NONE);
        check("mem_cnt", stall_cnt, exp_cnt);
        check("mem_cnt_abs", stall_cnt, 32'd6);
        check("mem_err_ok", {31'd0, mem_err}, 32'd0);

        // Branch held during a 2-cycle wait: flush only once back in RUN.
        mem_req = 1'b1;
        ex_br_taken = 1'b1;
        cyc("brw_1", C_MEM);
        cyc("brw_2", C_MEM);
        mem_ack = 1'b1;
        cyc("brw_3", C_MEM);
        mem_req = 1'b0;
        mem_ack = 1'b0;
        cyc("brw_flush", C_BRANCH);
        clear_ex;

        // Timeout: 16 stall cycles, then error flag and release.
        mem_req = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc("tmo_stall", C_MEM);
            if (i == 14) check("tmo_err_early", {31'd0, mem_err}, 32'd0);
        end
        check("tmo_err", {31'd0, mem_err}, 32'd1);
        mem_req = 1'b0;
        cyc("tmo_release", C_NONE);
        check("tmo_err_sticky", {31'd0, mem_err}, 32'd1);
        check("tmo_cnt", stall_cnt, exp_cnt);

        // Asynchronous reset in the middle of MEM_WAIT.
        mem_req = 1'b1;
        cyc("rstw_1", C_MEM);
        #1 rst_n = 1'b0;
        #1;
        check("rstw_ctrl", {25'd0, ctrl}, 32'd0);
        check("rstw_cnt", stall_cnt, 32'd0);
        check("rstw_err", {31'd0, mem_err}, 32'd0);
        mem_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_cnt = 32'd0;
        cyc("rstw_run", C_NONE);

        // Saturation: 20 load-use stall cycles.
        set_load_use(5'd5);
        for (int i = 0; i < 20; i++) cyc("sat_lduse", C_LDUSE);
        clear_ex;
        check("sat_cnt4", {28'd0, s_stall_cnt}, 32'd15);
        check("sat_cnt32", stall_cnt, 32'd20);
        check("sat_exp", stall_cnt, exp_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
